div_share_scheduler: RTL and testbench

- Shares one sequential restoring divider (8-bit unsigned dividend, 4-bit unsigned divisor) between N requesters.
- Arbitration is round-robin with valid/ready handshakes on both sides.
- Each result is returned with the winning requester's ID, an 8-bit quotient, a 4-bit remainder and a divide-by-zero flag.
- Sits between the fixed-point arithmetic clients and the division datapath; it is the only path by which clients reach division.

---
 rtl/div_share_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_div_share_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_scheduler.sv
// Round-robin front end that shares one 8-by-4-bit sequential restoring divider among N requesters.
// Each result returns tagged with the index of the requester that issued it.
module div_share_scheduler #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [8*N-1:0]   req_a,
    input  logic [4*N-1:0]   req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [IDW-1:0]   resp_id,
    output logic [7:0]       resp_quot,
    output logic [3:0]       resp_rem,
    output logic             resp_dz,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [IDW-1:0] ptr_r, id_r, win_idx_s, cand_s;
    logic           win_any_s, accept_s;
    logic [7:0]     a_sel_s, quot_r, step_quot_s;
    logic [3:0]     b_sel_s, b_r;
    // Partial remainder stays below b, so its top bit is never needed in storage.
    logic [3:0]     prem_r, step_prem_s;
    logic [4:0]     shifted_s, trial_s;
    logic [2:0]     cnt_r;
    logic           dz_r, resp_valid_r, busy_r;

    // Round-robin pick: the valid requester at the smallest offset from ptr wins.
    always_comb begin
        win_any_s = 1'b0;
        win_idx_s = '0;
        cand_s    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand_s    = IDW'((int'(ptr_r) + k) % N);
            win_any_s = win_any_s | req_valid[cand_s];
            win_idx_s = req_valid[cand_s] ? cand_s : win_idx_s;
        end
    end

    assign accept_s = (state_r == IDLE) && win_any_s;

    // One-hot grant, only offered while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && accept_s) begin
            req_ready[win_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        a_sel_s = 8'd0;
        b_sel_s = 4'd0;
        for (int i = 0; i < N; i++) begin
            a_sel_s = (win_idx_s == IDW'(i)) ? req_a[8*i +: 8] : a_sel_s;
            b_sel_s = (win_idx_s == IDW'(i)) ? req_b[4*i +: 4] : b_sel_s;
        end
    end

    // One restoring step: shift in the next dividend bit, subtract b if it fits.
    always_comb begin
        shifted_s = {prem_r, quot_r[7]};
        trial_s   = shifted_s - {1'b0, b_r};
        if (!trial_s[4]) begin
            step_prem_s = trial_s[3:0];
            step_quot_s = {quot_r[6:0], 1'b1};
        end else begin
            step_prem_s = shifted_s[3:0];
            step_quot_s = {quot_r[6:0], 1'b0};
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (b_sel_s == 4'd0) ? DONE : BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 3'd7) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, pointer advance and divider iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r  <= '0;
            id_r   <= '0;
            b_r    <= 4'd0;
            quot_r <= 8'd0;
            prem_r <= 4'd0;
            cnt_r  <= 3'd0;
            dz_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        id_r  <= win_idx_s;
                        ptr_r <= (win_idx_s == IDW'(N - 1)) ? '0 : win_idx_s + IDW'(1);
                        b_r   <= b_sel_s;
                        cnt_r <= 3'd0;
                        if (b_sel_s == 4'd0) begin
                            quot_r <= 8'hFF;
                            prem_r <= a_sel_s[3:0];
                            dz_r   <= 1'b1;
                        end else begin
                            quot_r <= a_sel_s;
                            prem_r <= 4'd0;
                            dz_r   <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    quot_r <= step_quot_s;
                    prem_r <= step_prem_s;
                    cnt_r  <= cnt_r + 3'd1;
                end
                DONE:    cnt_r <= 3'd0;
                default: cnt_r <= 3'd0;
            endcase
        end
    end

    // Status flags registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            resp_valid_r <= (state_nxt_s == DONE);
            busy_r       <= (state_nxt_s != IDLE);
        end
    end

    assign resp_valid = resp_valid_r;
    assign busy       = busy_r;
    assign resp_id    = id_r;
    assign resp_quot  = quot_r;
    assign resp_rem   = prem_r;
    assign resp_dz    = dz_r;

endmodule

// File: tb/tb_div_share_scheduler.sv
// Directed bench for div_share_scheduler: a transaction-level model (integer divide, round-robin
// pick, fixed latencies) is compared against the DUT every cycle, plus hand-computed spot checks.
module tb_div_share_scheduler;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_a = '0;
    logic [4*N-1:0] req_b = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b1;
    logic [IDW-1:0] resp_id;
    logic [7:0]     resp_quot;
    logic [3:0]     resp_rem;
    logic           resp_dz;
    logic           busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_share_scheduler #(.N(N), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_quot(resp_quot), .resp_rem(resp_rem),
        .resp_dz(resp_dz), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int m_ptr  = 0;
    int m_left = 0;
    int m_id   = 0;
    int m_q    = 0;
    int m_r    = 0;
    bit m_resp = 1'b0;
    bit m_dz   = 1'b0;

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    initial begin : model
        int w, a, b;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ptr = 0; m_left = 0; m_resp = 1'b0;
            end else if (m_resp) begin
                if (resp_ready) m_resp = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_resp = 1'b1;
            end else begin
                w = rr_pick(req_valid, m_ptr);
                if (w >= 0) begin
                    a = int'(req_a[8*w +: 8]);
                    b = int'(req_b[4*w +: 4]);
                    m_id  = w;
                    m_ptr = (w + 1) % N;
                    if (b == 0) begin
                        m_q = 255; m_r = a % 16; m_dz = 1'b1; m_resp = 1'b1;
                    end else begin
                        m_q = a / b; m_r = a % b; m_dz = 1'b0; m_left = 8;
                    end
                end
            end
        end
    end

    initial begin : compare
        int w;
        logic [N-1:0] exp_ready;
        forever begin
            @(negedge clk);
            exp_ready = '0;
            if (rst_n && !m_resp && m_left == 0) begin
                w = rr_pick(req_valid, m_ptr);
                if (w >= 0) exp_ready[w] = 1'b1;
            end
            chk("req_ready", req_ready, exp_ready);
            chk("busy", busy, m_resp || m_left > 0);
            chk("resp_valid", resp_valid, m_resp);
            if (m_resp) begin
                chk("resp_id", resp_id, m_id);
                chk("resp_quot", resp_quot, m_q);
                chk("resp_rem", resp_rem, m_r);
                chk("resp_dz", resp_dz, m_dz);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_quot", resp_quot, 0);
        chk("rst_resp_id", resp_id, 0);
        rst_n = 1'b1;
    endtask

    // Waits for the first grant, checks it is requester i, lets it be accepted.
    task automatic wait_grant(input int i, input bit drop);
        int n = 0;
        bit got = 1'b0;
        logic [N-1:0] want = '0;
        want[i] = 1'b1;
        while (!got && n < 60) begin
            @(negedge clk);
            got = (req_ready != '0);
            n++;
        end
        chk("grant_seen", got, 1);
        chk("grant_who", req_ready, want);
        @(posedge clk);
        #1;
        if (drop) req_valid[i] = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        bit got = 1'b0;
        lat = 0;
        while (!got && lat < 60) begin
            @(negedge clk);
            got = resp_valid;
            if (!got) lat++;
        end
        chk("resp_seen", got, 1);
    endtask

    task automatic do_op(input int i, input int a, input int b, input int q, input int r,
                         input int dz, input int lat_exp);
        int lat;
        req_a[8*i +: 8] = 8'(a);
        req_b[4*i +: 4] = 4'(b);
        req_valid[i] = 1'b1;
        wait_grant(i, 1'b1);
        wait_resp(lat);
        chk("latency", lat, lat_exp);
        chk("lit_id", resp_id, i);
        chk("lit_quot", resp_quot, q);
        chk("lit_rem", resp_rem, r);
        chk("lit_dz", resp_dz, dz);
        tick();
        chk("resp_consumed", resp_valid, 0);
    endtask

    initial begin : stim
        int lat;
        int order [5] = '{0, 1, 2, 3, 0};
        #1;
        do_reset();

        do_op(0, 100, 7, 14, 2, 0, 8);
        do_op(2, 8'hA5, 0, 255, 5, 1, 0);

        // Round-robin fairness from a freshly reset pointer.
        do_reset();
        req_a = {8'd250, 8'd13, 8'd77, 8'd200};
        req_b = {4'd11, 4'd0, 4'd5, 4'd9};
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) wait_grant(order[g], 1'b0);
        req_valid = '0;
        repeat (12) tick();
        chk("rr_idle", busy, 0);

        // Back-pressure with another requester waiting.
        resp_ready = 1'b0;
        req_a[15:8] = 8'd255;
        req_b[7:4]  = 4'd1;
        req_valid[1] = 1'b1;
        wait_grant(1, 1'b1);
        req_a[31:24] = 8'd60;
        req_b[15:12] = 4'd7;
        req_valid[3] = 1'b1;
        wait_resp(lat);
        chk("bp_latency", lat, 8);
        for (int c = 0; c < 5; c++) begin
            chk("bp_quot", resp_quot, 255);
            chk("bp_rem", resp_rem, 0);
            chk("bp_no_grant", req_ready, 0);
            chk("bp_hold", resp_valid, 1);
            tick();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_still_valid", resp_valid, 1);
        tick();
        chk("bp_released", resp_valid, 0);
        wait_grant(3, 1'b1);
        wait_resp(lat);
        chk("bp_next_quot", resp_quot, 8);
        chk("bp_next_rem", resp_rem, 4);
        tick();

        // Edge operands.
        do_op(0, 0, 15, 0, 0, 0, 8);
        do_op(0, 255, 15, 17, 0, 0, 8);
        do_op(0, 254, 15, 16, 14, 0, 8);

        // Reset on the 4th BUSY cycle, then ptr must be back at 0.
        req_a[7:0] = 8'd100;
        req_b[3:0] = 4'd3;
        req_valid[0] = 1'b1;
        wait_grant(0, 1'b1);
        repeat (3) tick();
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        req_a[15:0] = {8'd90, 8'd50};
        req_b[7:0]  = {4'd4, 4'd6};
        req_valid   = 4'b0011;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_grant(0, 1'b1);
        wait_resp(lat);
        chk("post_rst_latency", lat, 8);
        chk("post_rst_id", resp_id, 0);
        chk("post_rst_quot", resp_quot, 8);
        chk("post_rst_rem", resp_rem, 2);
        tick();
        wait_grant(1, 1'b1);
        wait_resp(lat);
        chk("post_rst_id1", resp_id, 1);
        chk("post_rst_quot1", resp_quot, 22);
        chk("post_rst_rem1", resp_rem, 2);
        tick();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
